// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings, FSM states,
// and the lane helpers used by the store read-modify-write path.
package mem_access_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } mau_state_t;

   function automatic logic is_valid_f3(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

   function automatic logic is_sub_word(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_BU) || (funct3 == F3_H) || (funct3 == F3_HU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = byte_off[0];
         F3_W:        mis = (byte_off != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Replace the addressed byte/halfword lane of word with the low bits of data.
   function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  byte_off);
      logic [31:0] merged;
      merged = word;
      case (funct3)
         F3_B, F3_BU: merged[{byte_off, 3'b000} +: 8]     = data[7:0];
         F3_H, F3_HU: merged[{byte_off[1], 4'b0000} +: 16] = data[15:0];
         default:     merged = data;
      endcase
      return merged;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Combinational load formatter: selects the byte/halfword lane of a memory word
// and sign- or zero-extends it; unsupported funct3 codes yield zero.
module load_aligner
   import mem_access_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      byte_off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      lane_b = word[{byte_off, 3'b000} +: 8];
      lane_h = word[{byte_off[1], 4'b0000} +: 16];
      result = '0;
      case (funct3)
         F3_B:    result = {{(XLEN-8){lane_b[7]}}, lane_b};
         F3_BU:   result = {{(XLEN-8){1'b0}}, lane_b};
         F3_H:    result = {{(XLEN-16){lane_h[15]}}, lane_h};
         F3_HU:   result = {{(XLEN-16){1'b0}}, lane_h};
         F3_W:    result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: formats loads, runs SB/SH as a stalled read-modify-write.
// Optional macro MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of force-aligning them.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] dmem_read_data,
   output logic [XLEN-1:0] dmem_address,
   output logic            dmem_write_en,
   output logic [XLEN-1:0] dmem_write_data,
   output logic            stall,
   output logic [XLEN-1:0] wb_load_data,
   output logic            misaligned
);

   mau_state_t      state, state_next;
   logic [XLEN-1:0] eff_address;
   logic [XLEN-1:0] load_result;
   logic [XLEN-1:0] rmw_address;
   logic [XLEN-1:0] rmw_word;
   logic            is_store;
   logic            is_load;
   logic            f3_valid;
   logic            trap;
   logic            latch_rmw;

   // A simultaneous read and write is handled as a store.
   assign is_store = mem_write;
   assign is_load  = mem_read && !mem_write;
   assign f3_valid = is_valid_f3(funct3);

`ifdef MISALIGN_TRAP_EN
   assign trap        = (mem_read || mem_write) && f3_valid && is_misaligned(funct3, address[1:0]);
   assign eff_address = address;
`else
   assign trap = 1'b0;
   always_comb begin
      eff_address = address;
      case (funct3)
         F3_H, F3_HU: eff_address[0]   = 1'b0;
         F3_W:        eff_address[1:0] = 2'b00;
         default:     eff_address      = address;
      endcase
   end
`endif

   load_aligner #(.XLEN(XLEN)) u_load_aligner (
      .word     (dmem_read_data),
      .byte_off (eff_address[1:0]),
      .funct3   (funct3),
      .result   (load_result)
   );

   always_comb begin
      state_next      = state;
      dmem_address    = eff_address;
      dmem_write_en   = 1'b0;
      dmem_write_data = store_data;
      stall           = 1'b0;
      latch_rmw       = 1'b0;
      case (state)
         IDLE: begin
            if (is_store && f3_valid && !trap) begin
               if (is_sub_word(funct3)) begin
                  stall      = 1'b1;
                  latch_rmw  = 1'b1;
                  state_next = RMW_WR;
               end else begin
                  dmem_write_en = !reset;
               end
            end
         end
         RMW_WR: begin
            dmem_address    = rmw_address;
            dmem_write_data = rmw_word;
            dmem_write_en   = !reset;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wb_load_data <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            if (trap)
               wb_load_data <= '0;
            else if (is_load)
               wb_load_data <= load_result;
         end
      end
   end

   // NOTE: the RMW holding registers carry no reset; they are only read in RMW_WR, right after being loaded.
   always_ff @(posedge clk) begin
      if (latch_rmw) begin
         rmw_address <= eff_address;
         rmw_word    <= merge_lanes(dmem_read_data, store_data, funct3, eff_address[1:0]);
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset)
         misaligned <= 1'b0;
      else
         misaligned <= (state == IDLE) && trap;
   end
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// against a word-array reference model of memory and load formatting.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic [31:0] dmem_read_data;
   logic [31:0] dmem_address;
   logic        dmem_write_en;
   logic [31:0] dmem_write_data;
   logic        stall;
   logic [31:0] wb_load_data;
   logic        misaligned;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic [31:0] model_wb;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.XLEN(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .funct3          (funct3),
      .address         (address),
      .store_data      (store_data),
      .dmem_read_data  (dmem_read_data),
      .dmem_address    (dmem_address),
      .dmem_write_en   (dmem_write_en),
      .dmem_write_data (dmem_write_data),
      .stall           (stall),
      .wb_load_data    (wb_load_data),
      .misaligned      (misaligned)
   );

   assign dmem_read_data = mem[dmem_address[7:2]];

   always @(posedge clk)
      if (dmem_write_en === 1'b1)
         mem[dmem_address[7:2]] <= dmem_write_data;

   // Access size in bytes, 0 for unsupported codes.
   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   task automatic poke(input int idx, input logic [31:0] val);
      mem[idx]     = val;
      ref_mem[idx] = val;
   endtask

   // Reference behaviour of one instruction: updates ref_mem/model_wb and predicts stall/write counts.
   task automatic model_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int e_stalls, output int e_writes, output logic e_mis);
      int          sz;
      int          a;
      int          idx;
      int          sh;
      logic [31:0] mask;
      logic [31:0] w;
      sz = size_of(f3);
      a  = int'(addr);
      e_stalls = 0;
      e_writes = 0;
      e_mis    = 1'b0;
      if (!rd && !wr) return;
      if (sz == 0) begin
         if (!wr) model_wb = 32'h0;
         return;
      end
`ifdef MISALIGN_TRAP_EN
      if (a % sz != 0) begin
         model_wb = 32'h0;
         e_mis    = 1'b1;
         return;
      end
`else
      a = a - (a % sz);
`endif
      idx = a / 4;
      sh  = (a % 4) * 8;
      if (wr) begin
         mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'h1 << (sz * 8)) - 32'h1) << sh);
         ref_mem[idx] = (ref_mem[idx] & ~mask) | ((data << sh) & mask);
         e_writes = 1;
         e_stalls = (sz == 4) ? 0 : 1;
      end else begin
         w = ref_mem[idx] >> sh;
         if (sz == 1) begin
            model_wb = w & 32'hFF;
            if (!f3[2] && w[7]) model_wb = model_wb | 32'hFFFF_FF00;
         end else if (sz == 2) begin
            model_wb = w & 32'hFFFF;
            if (!f3[2] && w[15]) model_wb = model_wb | 32'hFFFF_0000;
         end else begin
            model_wb = w;
         end
      end
   endtask

   // Drives one instruction, holding it while stall is high; called and returning at posedge+1.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         output int stalls, output int writes,
                         output logic [31:0] wb, output logic mis);
      logic st;
      mem_read   = rd;
      mem_write  = wr;
      funct3     = f3;
      address    = addr;
      store_data = data;
      stalls = 0;
      writes = 0;
      st     = 1'b1;
      for (int c = 0; c < 4 && st; c++) begin
         #1;
         st = stall;
         if (stall === 1'b1) stalls++;
         if (dmem_write_en === 1'b1) writes++;
         @(posedge clk);
         #1;
      end
      if (st !== 1'b0) stalls = 99;
      wb  = wb_load_data;
      mis = misaligned;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      address = 32'h0; store_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      total++; if (dmem_write_en !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", dmem_write_en); end
      total++; if (wb_load_data !== 32'h0) begin bad++; $display("FAIL reset_wb: got %h want 0", wb_load_data); end
      total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", misaligned); end
      reset    = 1'b0;
      model_wb = 32'h0;
   endtask

   task automatic test_sw_lw();
      int st, wr, es, ew; logic [31:0] wb; logic mis, em;
      run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, st, wr, wb, mis);
      model_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, es, ew, em);
      total++; if (st !== 0) begin bad++; $display("FAIL sw_stall: got %0d want 0", st); end
      total++; if (wr !== 1) begin bad++; $display("FAIL sw_writes: got %0d want 1", wr); end
      run_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, es, ew, em);
      total++; if (wb !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", wb); end
      total++; if (st !== 0) begin bad++; $display("FAIL lw_stall: got %0d want 0", st); end
   endtask

   task automatic test_sb();
      int st, wr, es, ew; logic [31:0] wb; logic mis, em;
      poke(4, 32'h1122_3344);
      run_op(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AB, st, wr, wb, mis);
      model_op(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AB, es, ew, em);
      total++; if (st !== 1) begin bad++; $display("FAIL sb_stall: got %0d want 1", st); end
      total++; if (wr !== 1) begin bad++; $display("FAIL sb_writes: got %0d want 1", wr); end
      total++; if (mem[4] !== 32'h1122_AB44) begin bad++; $display("FAIL sb_word: got %h want 1122ab44", mem[4]); end
      run_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, es, ew, em);
      total++; if (wb !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_data: got %h want 000000ab", wb); end
      run_op(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, es, ew, em);
      total++; if (wb !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_data: got %h want ffffffab", wb); end
   endtask

   task automatic test_sh();
      int st, wr, es, ew; logic [31:0] wb; logic mis, em;
      poke(8, 32'h0);
      run_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, st, wr, wb, mis);
      model_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, es, ew, em);
      total++; if (mem[8] !== 32'hBEEF_0000) begin bad++; $display("FAIL sh_word: got %h want beef0000", mem[8]); end
      total++; if (st !== 1) begin bad++; $display("FAIL sh_stall: got %0d want 1", st); end
      run_op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, es, ew, em);
      total++; if (wb !== 32'hFFFF_BEEF) begin bad++; $display("FAIL lh_data: got %h want ffffbeef", wb); end
      run_op(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, es, ew, em);
      total++; if (wb !== 32'h0000_BEEF) begin bad++; $display("FAIL lhu_data: got %h want 0000beef", wb); end
   endtask

   task automatic test_reset_in_rmw();
      int st, wr, es, ew; logic [31:0] wb; logic mis, em;
      poke(1, 32'hCAFE_F00D);
      run_op(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, es, ew, em);
      mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000;
      address = 32'h04; store_data = 32'h0000_0055;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_rmw_stall_in: got %b want 1", stall); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      mem_write = 1'b0;
      #1;
      total++; if (dmem_write_en !== 1'b0) begin bad++; $display("FAIL rst_rmw_wen: got %b want 0", dmem_write_en); end
      @(posedge clk);
      #1;
      reset    = 1'b0;
      model_wb = 32'h0;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_rmw_stall: got %b want 0", stall); end
      total++; if (wb_load_data !== 32'h0) begin bad++; $display("FAIL rst_rmw_wb: got %h want 0", wb_load_data); end
      total++; if (mem[1] !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_rmw_word: got %h want cafef00d", mem[1]); end
   endtask

   task automatic test_misaligned_lw();
      int st, wr, es, ew; logic [31:0] wb; logic mis, em;
      run_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, es, ew, em);
      run_op(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, st, wr, wb, mis);
      model_op(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, es, ew, em);
`ifdef MISALIGN_TRAP_EN
      total++; if (wb !== 32'h0) begin bad++; $display("FAIL mis_lw_data: got %h want 0", wb); end
      total++; if (mis !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", mis); end
`else
      total++; if (wb !== ref_mem[4]) begin bad++; $display("FAIL mis_lw_data: got %h want %h", wb, ref_mem[4]); end
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL mis_flag: got %b want 0", mis); end
`endif
      run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, st, wr, wb, mis);
      model_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, es, ew, em);
      total++; if (mis !== 1'b0) begin bad++; $display("FAIL mis_flag_clear: got %b want 0", mis); end
      total++; if (wb !== model_wb) begin bad++; $display("FAIL idle_wb_hold: got %h want %h", wb, model_wb); end
   endtask

   task automatic test_back_to_back();
      int st1, st2, wr1, wr2, es, ew; logic [31:0] wb; logic mis, em;
      poke(0, 32'h0);
      run_op(1'b0, 1'b1, 3'b000, 32'h00, 32'h0000_00AA, st1, wr1, wb, mis);
      model_op(1'b0, 1'b1, 3'b000, 32'h00, 32'h0000_00AA, es, ew, em);
      run_op(1'b0, 1'b1, 3'b000, 32'h01, 32'h0000_00BB, st2, wr2, wb, mis);
      model_op(1'b0, 1'b1, 3'b000, 32'h01, 32'h0000_00BB, es, ew, em);
      total++; if (st1 + st2 !== 2) begin bad++; $display("FAIL b2b_stalls: got %0d want 2", st1 + st2); end
      total++; if (wr1 + wr2 !== 2) begin bad++; $display("FAIL b2b_writes: got %0d want 2", wr1 + wr2); end
      total++; if (mem[0][15:0] !== 16'hBBAA) begin bad++; $display("FAIL b2b_low_half: got %h want bbaa", mem[0][15:0]); end
      run_op(1'b1, 1'b0, 3'b101, 32'h00, 32'h0, st1, wr1, wb, mis);
      model_op(1'b1, 1'b0, 3'b101, 32'h00, 32'h0, es, ew, em);
      total++; if (wb !== 32'h0000_BBAA) begin bad++; $display("FAIL b2b_lhu: got %h want 0000bbaa", wb); end
   endtask

   task automatic test_random();
      int st, wr, es, ew, kind; logic [31:0] wb, a, d; logic mis, em, rd, wn; logic [2:0] f3;
      for (int i = 0; i < 300; i++) begin
         kind = int'($urandom_range(0, 9));
         rd = (kind < 5) || (kind == 9);
         wn = (kind >= 5);
         if (kind == 0) rd = 1'b0;
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 63));
         d  = $urandom;
         run_op(rd, wn, f3, a, d, st, wr, wb, mis);
         model_op(rd, wn, f3, a, d, es, ew, em);
         total++; if (st !== es) begin bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, st, es); end
         total++; if (wr !== ew) begin bad++; $display("FAIL rnd_writes[%0d]: got %0d want %0d", i, wr, ew); end
         total++; if (wb !== model_wb) begin bad++; $display("FAIL rnd_wb[%0d]: got %h want %h", i, wb, model_wb); end
         total++; if (mis !== em) begin bad++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, mis, em); end
      end
      for (int j = 0; j < 16; j++) begin
         total++; if (mem[j] !== ref_mem[j]) begin bad++; $display("FAIL rnd_mem[%0d]: got %h want %h", j, mem[j], ref_mem[j]); end
      end
   endtask

   initial begin
      for (int k = 0; k < 64; k++) begin
         mem[k]     = 32'h0;
         ref_mem[k] = 32'h0;
      end
      model_wb = 32'h0;
      @(negedge clk);
      test_reset();
      test_sw_lw();
      test_sb();
      test_sh();
      test_reset_in_rmw();
      test_misaligned_lw();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
      $fatal(1);
   end

endmodule
